// File: rtl/udp_package.sv
// ---------------------------------------------------------------------------
// udp_package
// Shared definitions for the UDP fragment dispatcher slice.
//   BYTE_W / ID_W / COUNT_W : widths of the payload byte, the packet
//                             identifier and the two statistics counters.
//   state_t                 : dispatcher FSM states.
//   indexWidth()            : width of a slot index for a given slot count,
//                             never less than one bit so a one-slot build
//                             still has a legal index vector.
// ---------------------------------------------------------------------------
package udp_package;

   localparam int BYTE_W  = 8;
   localparam int ID_W    = 16;
   localparam int COUNT_W = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUTE = 2'd1,
      S_DROP  = 2'd2
   } state_t;

   function automatic int indexWidth(input int slots);
      return (slots > 1) ? $clog2(slots) : 1;
   endfunction

endpackage

// File: rtl/udp_slot_priority_select.sv
// ---------------------------------------------------------------------------
// udp_slot_priority_select
// Combinational lowest-index first-one finder.
//   request : one bit per slot, 1 = slot may be chosen
//   index   : index of the lowest set request bit (0 when none is set)
//   found   : 1 when at least one request bit is set
// ---------------------------------------------------------------------------
module udp_slot_priority_select #(
   parameter int WIDTH   = 4,
   parameter int INDEX_W = 2
) (
   input  logic [WIDTH-1:0]   request,
   output logic [INDEX_W-1:0] index,
   output logic               found
);

   // Scan from the top down so the last hit written is the lowest index.
   always_comb begin
      index = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (request[i]) begin
            index = INDEX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/udp_fragment_dispatcher.sv
// ---------------------------------------------------------------------------
// udp_fragment_dispatcher
// Routes each incoming packet to the lowest-index free downstream slot, or
// drops it when no slot is free. Every output is registered, so the slot_*
// strobes follow the input byte by exactly one cycle.
//   clock                : sole clock, rising edge
//   reset_n              : synchronous active-low reset
//   data / data_enable   : upstream payload byte and its valid
//   data_last            : final byte of a packet (only with data_enable)
//   fragment_id          : packet identifier, stable for the packet
//   slot_ready           : per-slot ready
//   slot_data            : byte broadcast to all slots
//   slot_fragment_id     : identifier broadcast to all slots
//   slot_data_enable     : one-hot write strobe
//   slot_data_last       : one-hot last strobe
//   packet_count         : packets routed (wraps)
//   dropped_packet_count : packets discarded (wraps)
// ---------------------------------------------------------------------------
module udp_fragment_dispatcher
   import udp_package::*;
#(
   parameter int SLOT_COUNT = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [BYTE_W-1:0]     data,
   input  logic                  data_enable,
   input  logic                  data_last,
   input  logic [ID_W-1:0]       fragment_id,
   input  logic [SLOT_COUNT-1:0] slot_ready,
   output logic [BYTE_W-1:0]     slot_data,
   output logic [ID_W-1:0]       slot_fragment_id,
   output logic [SLOT_COUNT-1:0] slot_data_enable,
   output logic [SLOT_COUNT-1:0] slot_data_last,
   output logic [COUNT_W-1:0]    packet_count,
   output logic [COUNT_W-1:0]    dropped_packet_count
);

   localparam int INDEX_W = indexWidth(SLOT_COUNT);

   state_t                state_q, state_d;
   logic [INDEX_W-1:0]    slotIndex_q, slotIndex_d;
   logic [SLOT_COUNT-1:0] reservation_q, reservation_d;
   logic [BYTE_W-1:0]     slotData_q, slotData_d;
   logic [ID_W-1:0]       slotFragmentId_q, slotFragmentId_d;
   logic [SLOT_COUNT-1:0] slotDataEnable_q, slotDataEnable_d;
   logic [SLOT_COUNT-1:0] slotDataLast_q, slotDataLast_d;
   logic [COUNT_W-1:0]    packetCount_q, packetCount_d;
   logic [COUNT_W-1:0]    droppedCount_q, droppedCount_d;

   logic [SLOT_COUNT-1:0] candidates;
   logic [INDEX_W-1:0]    selIndex;
   logic                  selFound;

   // A reserved slot is skipped even if it still reports ready: its ready
   // output lags by a register, so it cannot yet reflect the packet we sent.
   assign candidates = slot_ready & ~reservation_q;

   udp_slot_priority_select #(
      .WIDTH   (SLOT_COUNT),
      .INDEX_W (INDEX_W)
   ) u_select (
      .request (candidates),
      .index   (selIndex),
      .found   (selFound)
   );

   // Next-state logic. Strobes default to 0 so they last one cycle only.
   // The reservation clear is applied before the set, so a slot selected
   // in the same cycle its ready reads 0 stays reserved.
   always_comb begin
      state_d          = state_q;
      slotIndex_d      = slotIndex_q;
      reservation_d    = reservation_q & slot_ready;
      slotData_d       = slotData_q;
      slotFragmentId_d = slotFragmentId_q;
      slotDataEnable_d = '0;
      slotDataLast_d   = '0;
      packetCount_d    = packetCount_q;
      droppedCount_d   = droppedCount_q;

      if (data_enable) begin
         slotData_d       = data;
         slotFragmentId_d = fragment_id;
         case (state_q)
            S_IDLE: begin
               if (selFound) begin
                  slotDataEnable_d[selIndex] = 1'b1;
                  slotDataLast_d[selIndex]   = data_last;
                  reservation_d[selIndex]    = 1'b1;
                  packetCount_d              = packetCount_q + COUNT_W'(1);
                  slotIndex_d                = selIndex;
                  if (!data_last) begin
                     state_d = S_ROUTE;
                  end
               end else begin
                  droppedCount_d = droppedCount_q + COUNT_W'(1);
                  if (!data_last) begin
                     state_d = S_DROP;
                  end
               end
            end
            S_ROUTE: begin
               slotDataEnable_d[slotIndex_q] = 1'b1;
               slotDataLast_d[slotIndex_q]   = data_last;
               if (data_last) begin
                  state_d = S_IDLE;
               end
            end
            S_DROP: begin
               if (data_last) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and output registers; reset abandons any packet in flight.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q          <= S_IDLE;
         slotIndex_q      <= '0;
         reservation_q    <= '0;
         slotData_q       <= '0;
         slotFragmentId_q <= '0;
         slotDataEnable_q <= '0;
         slotDataLast_q   <= '0;
         packetCount_q    <= '0;
         droppedCount_q   <= '0;
      end else begin
         state_q          <= state_d;
         slotIndex_q      <= slotIndex_d;
         reservation_q    <= reservation_d;
         slotData_q       <= slotData_d;
         slotFragmentId_q <= slotFragmentId_d;
         slotDataEnable_q <= slotDataEnable_d;
         slotDataLast_q   <= slotDataLast_d;
         packetCount_q    <= packetCount_d;
         droppedCount_q   <= droppedCount_d;
      end
   end

   assign slot_data            = slotData_q;
   assign slot_fragment_id     = slotFragmentId_q;
   assign slot_data_enable     = slotDataEnable_q;
   assign slot_data_last       = slotDataLast_q;
   assign packet_count         = packetCount_q;
   assign dropped_packet_count = droppedCount_q;

endmodule

// File: tb/tb_udp_fragment_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_udp_fragment_dispatcher
// Directed vector table for udp_fragment_dispatcher (SLOT_COUNT = 4), plus a
// long run of single-byte packets that drives packet_count through its wrap.
// ---------------------------------------------------------------------------
module tb_udp_fragment_dispatcher;

   logic        clock;
   logic        reset_n;
   logic [7:0]  data;
   logic        data_enable;
   logic        data_last;
   logic [15:0] fragment_id;
   logic [3:0]  slot_ready;
   logic [7:0]  slot_data;
   logic [15:0] slot_fragment_id;
   logic [3:0]  slot_data_enable;
   logic [3:0]  slot_data_last;
   logic [15:0] packet_count;
   logic [15:0] dropped_packet_count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rstN;
      logic        de;
      logic        dl;
      logic [7:0]  d;
      logic [15:0] id;
      logic [3:0]  rdy;
      logic [3:0]  expEn;
      logic [3:0]  expLast;
      logic [7:0]  expData;
      logic [15:0] expId;
      logic [15:0] expPkt;
      logic [15:0] expDrop;
   } vec_t;

   vec_t vecs[$];

   udp_fragment_dispatcher #(.SLOT_COUNT(4)) dut (
      .clock                (clock),
      .reset_n              (reset_n),
      .data                 (data),
      .data_enable          (data_enable),
      .data_last            (data_last),
      .fragment_id          (fragment_id),
      .slot_ready           (slot_ready),
      .slot_data            (slot_data),
      .slot_fragment_id     (slot_fragment_id),
      .slot_data_enable     (slot_data_enable),
      .slot_data_last       (slot_data_last),
      .packet_count         (packet_count),
      .dropped_packet_count (dropped_packet_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic addVec(input logic rstN, input logic de, input logic dl,
                         input logic [7:0] d, input logic [15:0] id, input logic [3:0] rdy,
                         input logic [3:0] expEn, input logic [3:0] expLast,
                         input logic [7:0] expData, input logic [15:0] expId,
                         input logic [15:0] expPkt, input logic [15:0] expDrop);
      vec_t v;
      v.rstN = rstN; v.de = de; v.dl = dl; v.d = d; v.id = id; v.rdy = rdy;
      v.expEn = expEn; v.expLast = expLast; v.expData = expData;
      v.expId = expId; v.expPkt = expPkt; v.expDrop = expDrop;
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic applyStimulus(input logic rstN, input logic de, input logic dl,
                                input logic [7:0] d, input logic [15:0] id,
                                input logic [3:0] rdy);
      reset_n     = rstN;
      data_enable = de;
      data_last   = dl;
      data        = d;
      fragment_id = id;
      slot_ready  = rdy;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   int pktModel;

   initial begin
      reset_n = 1'b0; data_enable = 1'b0; data_last = 1'b0;
      data = '0; fragment_id = '0; slot_ready = '0;

      //     rst de dl data   id        rdy      en       last     data   id        pkt    drop
      // reset and idle
      addVec(0, 0, 0, 8'h00, 16'h0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 16'h0000, 16'd0, 16'd0);
      addVec(1, 0, 0, 8'h00, 16'h0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 16'h0000, 16'd0, 16'd0);
      // 3-byte packet id 0x1234 to slot 0
      addVec(1, 1, 0, 8'hA1, 16'h1234, 4'b1111, 4'b0001, 4'b0000, 8'hA1, 16'h1234, 16'd1, 16'd0);
      addVec(1, 1, 0, 8'hA2, 16'h1234, 4'b1111, 4'b0001, 4'b0000, 8'hA2, 16'h1234, 16'd1, 16'd0);
      addVec(1, 1, 1, 8'hA3, 16'h1234, 4'b1111, 4'b0001, 4'b0001, 8'hA3, 16'h1234, 16'd1, 16'd0);
      // ready low for a cycle releases the reservation
      addVec(1, 0, 0, 8'hFF, 16'hFFFF, 4'b0000, 4'b0000, 4'b0000, 8'hA3, 16'h1234, 16'd1, 16'd0);
      // back-to-back A then B: B skips reserved slot 0
      addVec(1, 1, 0, 8'h10, 16'h00AA, 4'b1111, 4'b0001, 4'b0000, 8'h10, 16'h00AA, 16'd2, 16'd0);
      addVec(1, 1, 1, 8'h11, 16'h00AA, 4'b1111, 4'b0001, 4'b0001, 8'h11, 16'h00AA, 16'd2, 16'd0);
      addVec(1, 1, 0, 8'h20, 16'h00BB, 4'b1111, 4'b0010, 4'b0000, 8'h20, 16'h00BB, 16'd3, 16'd0);
      addVec(1, 1, 1, 8'h21, 16'h00BB, 4'b1111, 4'b0010, 4'b0010, 8'h21, 16'h00BB, 16'd3, 16'd0);
      // data_last without data_enable is ignored
      addVec(1, 0, 1, 8'hEE, 16'hEEEE, 4'b1111, 4'b0000, 4'b0000, 8'h21, 16'h00BB, 16'd3, 16'd0);
      // no slot ready: 5-byte packet dropped, with a gap cycle inside
      addVec(1, 1, 0, 8'h30, 16'h0C0C, 4'b0000, 4'b0000, 4'b0000, 8'h30, 16'h0C0C, 16'd3, 16'd1);
      addVec(1, 1, 0, 8'h31, 16'h0C0C, 4'b0000, 4'b0000, 4'b0000, 8'h31, 16'h0C0C, 16'd3, 16'd1);
      addVec(1, 0, 0, 8'hEE, 16'h0C0C, 4'b1111, 4'b0000, 4'b0000, 8'h31, 16'h0C0C, 16'd3, 16'd1);
      addVec(1, 1, 0, 8'h32, 16'h0C0C, 4'b1111, 4'b0000, 4'b0000, 8'h32, 16'h0C0C, 16'd3, 16'd1);
      addVec(1, 1, 0, 8'h33, 16'h0C0C, 4'b1111, 4'b0000, 4'b0000, 8'h33, 16'h0C0C, 16'd3, 16'd1);
      addVec(1, 1, 1, 8'h34, 16'h0C0C, 4'b0000, 4'b0000, 4'b0000, 8'h34, 16'h0C0C, 16'd3, 16'd1);
      // next packet with only slot 2 ready
      addVec(1, 1, 0, 8'h40, 16'h0D0D, 4'b0100, 4'b0100, 4'b0000, 8'h40, 16'h0D0D, 16'd4, 16'd1);
      addVec(1, 1, 1, 8'h41, 16'h0D0D, 4'b0100, 4'b0100, 4'b0100, 8'h41, 16'h0D0D, 16'd4, 16'd1);
      // single-byte packets stay in idle
      addVec(1, 1, 1, 8'h50, 16'h0E0E, 4'b1111, 4'b0001, 4'b0001, 8'h50, 16'h0E0E, 16'd5, 16'd1);
      addVec(1, 0, 0, 8'h00, 16'h0E0E, 4'b0000, 4'b0000, 4'b0000, 8'h50, 16'h0E0E, 16'd5, 16'd1);
      addVec(1, 1, 1, 8'h51, 16'h0E0F, 4'b1111, 4'b0001, 4'b0001, 8'h51, 16'h0E0F, 16'd6, 16'd1);
      // reset on byte 2 of a 4-byte packet; bytes 3-4 form a new packet
      addVec(1, 1, 0, 8'h60, 16'h0F0F, 4'b1111, 4'b0010, 4'b0000, 8'h60, 16'h0F0F, 16'd7, 16'd1);
      addVec(0, 1, 0, 8'h61, 16'h0F0F, 4'b1111, 4'b0000, 4'b0000, 8'h00, 16'h0000, 16'd0, 16'd0);
      addVec(1, 1, 0, 8'h62, 16'h0F0F, 4'b1111, 4'b0001, 4'b0000, 8'h62, 16'h0F0F, 16'd1, 16'd0);
      addVec(1, 1, 1, 8'h63, 16'h0F0F, 4'b1111, 4'b0001, 4'b0001, 8'h63, 16'h0F0F, 16'd1, 16'd0);
      // single-byte drop, then a routed packet right after
      addVec(1, 1, 1, 8'h70, 16'h1111, 4'b0000, 4'b0000, 4'b0000, 8'h70, 16'h1111, 16'd1, 16'd1);
      addVec(1, 1, 1, 8'h71, 16'h2222, 4'b0010, 4'b0010, 4'b0010, 8'h71, 16'h2222, 16'd2, 16'd1);

      @(negedge clock);
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rstN, vecs[i].de, vecs[i].dl, vecs[i].d, vecs[i].id, vecs[i].rdy);
         checkOutput($sformatf("v%0d enable", i), {12'd0, slot_data_enable}, {12'd0, vecs[i].expEn});
         checkOutput($sformatf("v%0d last", i), {12'd0, slot_data_last}, {12'd0, vecs[i].expLast});
         checkOutput($sformatf("v%0d data", i), {8'd0, slot_data}, {8'd0, vecs[i].expData});
         checkOutput($sformatf("v%0d id", i), slot_fragment_id, vecs[i].expId);
         checkOutput($sformatf("v%0d pkt", i), packet_count, vecs[i].expPkt);
         checkOutput($sformatf("v%0d drop", i), dropped_packet_count, vecs[i].expDrop);
      end

      // Counter wrap: alternate single-byte packets between slots 0 and 1,
      // dropping the other slot's ready so its reservation clears each cycle.
      pktModel = 2;
      while (pktModel < 16'hFFFF) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 8'h80, 16'h3333,
                       (pktModel[0] == 1'b0) ? 4'b0001 : 4'b0010);
         pktModel++;
      end
      checkOutput("pkt at ffff", packet_count, 16'hFFFF);
      checkOutput("drop before wrap", dropped_packet_count, 16'd1);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h81, 16'h4444, 4'b0100);
      checkOutput("pkt wrap", packet_count, 16'h0000);
      checkOutput("wrap enable", {12'd0, slot_data_enable}, 16'h0004);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 4'b0000);
      checkOutput("idle after wrap", {12'd0, slot_data_enable}, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
